// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing helpers for the register file / pending-write scoreboard.
// Pure compile-time functions, no logic.
// Imported by the interface, the top and the pending counter.
package regfile_scoreboard_pkg;

  // Address width for a register array of nregs entries (at least 1 bit).
  function automatic int addr_width(input int nregs);
    return (nregs <= 1) ? 1 : $clog2(nregs);
  endfunction

  // Largest value a cnt_w-bit pending counter may hold.
  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode / write-back bundle of the register file scoreboard.
// Read data and busy flags are combinational; wb_err is registered.
// issue_ready is the only backpressure: master holds issue_valid until accepted.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) ();
  localparam int AW = addr_width(NREGS);

  logic [NREAD-1:0]      rd_en;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  stall;
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic                  issue_ready;
  logic                  wb_valid;
  logic [AW-1:0]         wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  flush;
  logic                  wb_err;

  // Pipeline side (decode + write-back).
  modport master (
    output rd_en, rd_addr, issue_valid, issue_rd,
    output wb_valid, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, stall, issue_ready, wb_err
  );

  // Register file side.
  modport slave (
    input  rd_en, rd_addr, issue_valid, issue_rd,
    input  wb_valid, wb_addr, wb_data, flush,
    output rd_data, rd_busy, stall, issue_ready, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard_pending_counter.sv
// Per-register count of in-flight writes; clr wins over inc/dec.
// Count updates one cycle after inc/dec/clr; sat/cnt reflect current state.
// Never wraps: inc at saturation and dec at zero are ignored.
module regfile_scoreboard_pending_counter
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dec_eff;

  // Next count: clear, else +1/-1 unless inc and dec cancel out.
  always_comb begin
    cnt_d   = cnt_q;
    dec_eff = dec && (cnt_q != '0);
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec_eff && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_eff && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == CNT_MAX);
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-back bypass and per-register pending-write scoreboard.
// Reads/busy/stall are zero-latency; writes and counter updates land next cycle.
// issue_ready drops on flush or when the destination's counter is saturated.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input logic                clk,
  input logic                reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = addr_width(NREGS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]             regs_q [NREGS];
  logic [XLEN-1:0]             regs_d [NREGS];
  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            sat;
  logic [NREGS-1:1]            inc;
  logic [NREGS-1:1]            dec;
  logic                        issue_ready_c;
  logic                        issue_fire;
  logic                        wb_nz;
  logic                        wb_err_q;
  logic                        wb_err_d;
  logic [NREAD*XLEN-1:0]       rd_data_c;
  logic [NREAD-1:0]            rd_busy_c;

  assign wb_nz = bus.wb_valid && (bus.wb_addr != '0);

  // Issue is accepted unless flushing or the destination is already full; x0 is never counted.
  assign issue_ready_c = !bus.flush && ((bus.issue_rd == '0) || !sat[bus.issue_rd]);
  assign issue_fire    = bus.issue_valid && issue_ready_c && (bus.issue_rd != '0);

  for (genvar r = 0; r < NREGS; r++) begin : g_cnt
    if (r == 0) begin : g_zero
      assign cnt[0] = '0;
      assign sat[0] = 1'b0;
    end else begin : g_reg
      assign inc[r] = issue_fire && (bus.issue_rd == AW'(r));
      assign dec[r] = bus.wb_valid && (bus.wb_addr == AW'(r));
      regfile_scoreboard_pending_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc[r]),
        .dec   (dec[r]),
        .clr   (bus.flush),
        .cnt   (cnt[r]),
        .sat   (sat[r])
      );
    end
  end

  // Array write: write-back lands regardless of scoreboard state; x0 stays zero.
  always_comb begin
    regs_d = regs_q;
    if (wb_nz) regs_d[bus.wb_addr] = bus.wb_data;
  end

  // Register array storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Sticky error: write-back with nothing outstanding and no same-cycle issue to cover it.
  always_comb begin
    wb_err_d = wb_err_q;
    if (wb_nz && !bus.flush && (cnt[bus.wb_addr] == '0) &&
        !(issue_fire && (bus.issue_rd == bus.wb_addr))) begin
      wb_err_d = 1'b1;
    end
  end

  // Error flag storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wb_err_q <= 1'b0;
    else       wb_err_q <= wb_err_d;
  end

  // Read ports: bypass same-cycle write-back; the last outstanding write completing now is not a hazard.
  always_comb begin
    logic [AW-1:0] a;
    logic          hit;
    rd_data_c = '0;
    rd_busy_c = '0;
    a         = '0;
    hit       = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      a   = bus.rd_addr[i*AW +: AW];
      hit = (BYPASS != 0) && bus.wb_valid && (bus.wb_addr == a);
      if (!reset && (a != '0)) begin
        rd_data_c[i*XLEN +: XLEN] = hit ? bus.wb_data : regs_q[a];
        rd_busy_c[i]              = (cnt[a] != '0) && !(hit && (cnt[a] == CNT_ONE));
      end
    end
  end

  assign bus.rd_data     = rd_data_c;
  assign bus.rd_busy     = rd_busy_c;
  assign bus.issue_ready = reset || issue_ready_c;
  assign bus.stall       = !reset && ((|(bus.rd_en & rd_busy_c)) ||
                                      (bus.issue_valid && !issue_ready_c));
  assign bus.wb_err      = wb_err_q;
endmodule
